scenery_sched: RTL and testbench



---
 rtl/scenery_pkg.sv | 53 +++++
 rtl/newcipherRound.sv | 42 ++++
 rtl/scenery_sched.sv | 109 ++++++++++
 tb/tb_scenery_sched.sv | 569 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scenery_pkg.sv
// scenery_pkg: shared constants, FSM state type, S-box and
// the two-requester round-robin pick used by scenery_sched.
package scenery_pkg;

  localparam int NROUNDS = 28;
  localparam int BLK_W   = 64;
  localparam int KEY_W   = 64;
  localparam int RC_W    = 5;
  localparam int CNT_W   = $clog2(NROUNDS);

  localparam logic [RC_W-1:0] RC_INIT = 5'd1;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } sched_state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Returns the granted index; only meaningful when v0|v1.
  // On a tie the requester that did not win last time wins.
  function automatic logic pick(
    input logic v0,
    input logic v1,
    input logic last
  );
    if (v0 && v1) return ~last;
    return v1;
  endfunction

endpackage

// File: rtl/newcipherRound.sv
// newcipherRound: one combinational SCENERY round.
// res/k/cnt/rc in -> te (state), r_keys (key), rc1 (round const).
module newcipherRound
  import scenery_pkg::*;
(
  output logic [BLK_W-1:0] te,
  output logic [KEY_W-1:0] r_keys,
  output logic [RC_W-1:0]  rc1,
  input  logic [BLK_W-1:0] res,
  input  logic [KEY_W-1:0] k,
  input  logic [CNT_W-1:0] cnt,
  input  logic [RC_W-1:0]  rc
);

  logic [31:0] l;
  logic [31:0] r;
  logic [31:0] t;
  logic [31:0] s;
  logic [31:0] f;
  logic [KEY_W-1:0] kr;

  always_comb begin
    l = res[63:32];
    r = res[31:0];
    t = r ^ k[31:0];
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[4*i +: 4] = sbox(t[4*i +: 4]);
    end
    f = s ^ {s[28:0], s[31:29]}
          ^ {s[23:0], s[31:24]};
    te = {r, l ^ f};
    kr = {k[50:0], k[63:51]};
    kr[63:60] = sbox(kr[63:60]);
    kr[RC_W-1:0] = kr[RC_W-1:0] ^ rc;
    kr[8 +: CNT_W] = kr[8 +: CNT_W] ^ cnt;
    r_keys = kr;
    // 5-bit LFSR, x^5 + x^3 + 1
    rc1 = {rc[3:0], rc[4] ^ rc[2]};
  end

endmodule

// File: rtl/scenery_sched.sv
// scenery_sched: round-robin 2-requester front end for one
// iterative SCENERY round; req0/req1 valid/ready in, tagged out.
module scenery_sched
  import scenery_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [BLK_W-1:0] req0_state,
  input  logic [KEY_W-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [BLK_W-1:0] req1_state,
  input  logic [KEY_W-1:0] req1_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_result,
  output logic             out_id,
  output logic             busy
);

  sched_state_t     st;
  logic [BLK_W-1:0] st_q;
  logic [KEY_W-1:0] key_q;
  logic [RC_W-1:0]  rc_q;
  logic [CNT_W-1:0] cnt;
  logic             id_q;
  logic             last_grant;
  logic             ov;

  logic [BLK_W-1:0] te;
  logic [KEY_W-1:0] nk;
  logic [RC_W-1:0]  nrc;
  logic             gnt;
  logic             idle;

  assign idle = (st == IDLE);
  assign gnt  = pick(req0_valid, req1_valid,
                     last_grant);

  assign req0_ready = idle & req0_valid & ~gnt;
  assign req1_ready = idle & req1_valid & gnt;

  assign out_valid  = ov;
  assign out_result = st_q;
  assign out_id     = id_q;
  assign busy       = ~idle;

  newcipherRound u_round (
    .te     (te),
    .r_keys (nk),
    .rc1    (nrc),
    .res    (st_q),
    .k      (key_q),
    .cnt    (cnt),
    .rc     (rc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      st_q       <= '0;
      key_q      <= '0;
      rc_q       <= RC_INIT;
      cnt        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      ov         <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            st_q <= gnt ? req1_state
                        : req0_state;
            key_q <= gnt ? req1_key
                         : req0_key;
            rc_q       <= RC_INIT;
            cnt        <= '0;
            id_q       <= gnt;
            last_grant <= gnt;
            st         <= ROUND;
          end
        end
        ROUND: begin
          st_q  <= te;
          key_q <= nk;
          rc_q  <= nrc;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NROUNDS - 1)) begin
            st <= DONE;
            ov <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st <= IDLE;
            ov <= 1'b0;
          end
        end
        default: begin
          st <= IDLE;
          ov <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scenery_sched.sv
// tb_scenery_sched: randomized self-checking bench for
// scenery_sched against a word-level software cipher model.
module tb_scenery_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [63:0] req0_state = '0;
  logic [63:0] req0_key = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [63:0] req1_state = '0;
  logic [63:0] req1_key = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_id;
  logic        busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scenery_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_state (req0_state),
    .req0_key   (req0_key),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_state (req1_state),
    .req1_key   (req1_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_id     (out_id),
    .busy       (busy)
  );

  // Feistel cipher: 28 rounds, PRESENT S-box F-function,
  // key rotl13 + top-nibble S-box + rc/round-index injection.
  function automatic logic [63:0] model_encrypt(
    input logic [63:0] pt,
    input logic [63:0] key
  );
    logic [63:0] sbt;
    logic [31:0] l, r, x, s, f, nl;
    logic [63:0] k;
    int rc, idx;
    sbt = 64'h21748FE3DA09B65C;
    l = pt[63:32];
    r = pt[31:0];
    k = key;
    rc = 1;
    for (int rnd = 0; rnd < 28; rnd++) begin
      x = r ^ k[31:0];
      s = '0;
      for (int n = 0; n < 8; n++) begin
        idx = int'(x[4*n +: 4]);
        s[4*n +: 4] = sbt[4*idx +: 4];
      end
      f = s ^ ((s << 3) | (s >> 29))
            ^ ((s << 8) | (s >> 24));
      nl = r;
      r = l ^ f;
      l = nl;
      k = (k << 13) | (k >> 51);
      idx = int'(k[63:60]);
      k[63:60] = sbt[4*idx +: 4];
      k = k ^ 64'(rc) ^ (64'(rnd) << 8);
      rc = ((rc << 1) | (((rc >> 4) ^ (rc >> 2)) & 1))
           & 31;
    end
    return {l, r};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for requester n to be accepted; acc = accept edge.
  task automatic wait_accept(input int n, output int acc);
    bit hit;
    hit = 1'b0;
    acc = -1;
    for (int i = 0; i < 200 && !hit; i++) begin
      #1;
      if (n == 0 ? (req0_valid && req0_ready)
                 : (req1_valid && req1_ready)) begin
        hit = 1'b1;
        acc = cyc + 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout req%0d: got none, required accept",
               n);
    end
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_out(
    output logic [63:0] res,
    output logic        id,
    output int          seen
  );
    bit hit;
    hit = 1'b0;
    res = '0;
    id = 1'b0;
    seen = -1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        hit = 1'b1;
        res = out_result;
        id = out_id;
        seen = cyc;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: got no out_valid, required one");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b, required 0", busy);
    end
    checks++;
    if (out_result !== 64'h0 || out_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_out: got %h/%b, required 0/0",
               out_result, out_id);
    end
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rst_first_tie: got %b%b, required 10",
               req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [63:0] res;
    logic id;
    int acc, seen;
    do_reset();
    req0_state = 64'h0123456789ABCDEF;
    req0_key = 64'hFEDCBA9876543210;
    out_ready = 1'b1;
    req0_valid = 1'b1;
    wait_accept(0, acc);
    wait_out(res, id, seen);
    checks++;
    if (seen - acc != 28) begin
      errors++;
      $display("FAIL single_latency: got %0d, required 28",
               seen - acc);
    end
    checks++;
    if (res !== model_encrypt(64'h0123456789ABCDEF,
                              64'hFEDCBA9876543210)) begin
      errors++;
      $display("FAIL single_result: got %h, required %h", res,
               model_encrypt(64'h0123456789ABCDEF,
                             64'hFEDCBA9876543210));
    end
    checks++;
    if (id !== 1'b0) begin
      errors++;
      $display("FAIL single_id: got %b, required 0", id);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_done: got %b, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall: got %b/%b, required 0/0",
               busy, out_valid);
    end
  endtask

  task automatic test_both();
    logic [64:0] q[$];
    logic [64:0] e;
    int gid[4];
    int gacc[4];
    int ng, nout;
    bit chg0, chg1;
    do_reset();
    out_ready = 1'b1;
    req0_state = rnd64();
    req0_key = rnd64();
    req1_state = rnd64();
    req1_key = rnd64();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    ng = 0;
    nout = 0;
    chg0 = 1'b0;
    chg1 = 1'b0;
    for (int i = 0; i < 400 && nout < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (chg0) begin
        req0_state = rnd64();
        req0_key = rnd64();
        chg0 = 1'b0;
      end
      if (chg1) begin
        req1_state = rnd64();
        req1_key = rnd64();
        chg1 = 1'b0;
      end
      if (ng >= 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL both_ready_excl: got 11, required not both");
      end
      if (req0_valid && req0_ready && ng < 4) begin
        gid[ng] = 0;
        gacc[ng] = cyc + 1;
        q.push_back({1'b0,
                     model_encrypt(req0_state, req0_key)});
        ng++;
        chg0 = 1'b1;
      end
      if (req1_valid && req1_ready && ng < 4) begin
        gid[ng] = 1;
        gacc[ng] = cyc + 1;
        q.push_back({1'b1,
                     model_encrypt(req1_state, req1_key)});
        ng++;
        chg1 = 1'b1;
      end
      if (out_valid === 1'b1) begin
        e = (q.size() > 0) ? q.pop_front() : 65'h0;
        checks++;
        if ({out_id, out_result} !== e) begin
          errors++;
          $display("FAIL both_out%0d: got %b/%h, required %b/%h",
                   nout, out_id, out_result, e[64], e[63:0]);
        end
        nout++;
      end
    end
    checks++;
    if (ng != 4 || nout != 4) begin
      errors++;
      $display("FAIL both_count: got %0d/%0d, required 4/4",
               ng, nout);
    end
    for (int i = 0; i < ng; i++) begin
      checks++;
      if (gid[i] != (i % 2)) begin
        errors++;
        $display("FAIL both_order%0d: got %0d, required %0d",
                 i, gid[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (gacc[i] - gacc[i-1] != 30) begin
          errors++;
          $display("FAIL both_spacing%0d: got %0d, required 30",
                   i, gacc[i] - gacc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res, held, exp0, exp1;
    logic id;
    int acc, seen;
    do_reset();
    req0_state = rnd64();
    req0_key = rnd64();
    exp0 = model_encrypt(req0_state, req0_key);
    out_ready = 1'b0;
    req0_valid = 1'b1;
    wait_accept(0, acc);
    req1_state = rnd64();
    req1_key = rnd64();
    exp1 = model_encrypt(req1_state, req1_key);
    req1_valid = 1'b1;
    wait_out(res, id, seen);
    held = res;
    checks++;
    if (res !== exp0 || id !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: got %b/%h, required 0/%h",
               id, res, exp0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== held) begin
        errors++;
        $display("FAIL bp_hold%0d: got %b/%h, required 1/%h",
                 i, out_valid, out_result, held);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b%b, required 00",
                 i, req0_ready, req1_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: got %b, required 1",
               req1_ready);
    end
    wait_accept(1, acc);
    wait_out(res, id, seen);
    checks++;
    if (res !== exp1 || id !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got %b/%h, required 1/%h",
               id, res, exp1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    logic id;
    int acc, seen;
    do_reset();
    req0_state = rnd64();
    req0_key = rnd64();
    out_ready = 1'b1;
    req0_valid = 1'b1;
    wait_accept(0, acc);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_now: got %b/%b, required 0/0",
               out_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    req0_state = 64'h0;
    req0_key = 64'h0;
    req0_valid = 1'b1;
    wait_accept(0, acc);
    wait_out(res, id, seen);
    checks++;
    if (seen - acc != 28) begin
      errors++;
      $display("FAIL midrst_latency: got %0d, required 28",
               seen - acc);
    end
    checks++;
    if (res !== model_encrypt(64'h0, 64'h0) || id !== 1'b0) begin
      errors++;
      $display("FAIL midrst_result: got %b/%h, required 0/%h",
               id, res, model_encrypt(64'h0, 64'h0));
    end
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    logic [63:0] res, exp0;
    logic id;
    int acc, seen;
    do_reset();
    out_ready = 1'b1;
    req0_state = rnd64();
    req0_key = rnd64();
    exp0 = model_encrypt(req0_state, req0_key);
    req0_valid = 1'b1;
    wait_accept(0, acc);
    repeat (5) @(negedge clk);
    req1_state = rnd64();
    req1_key = rnd64();
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL wd_ready: got %b, required 0", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_out(res, id, seen);
    checks++;
    if (res !== exp0 || id !== 1'b0) begin
      errors++;
      $display("FAIL wd_first: got %b/%h, required 0/%h",
               id, res, exp0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wd_no_accept: got %b/%b, required 0/0",
               busy, out_valid);
    end
    req0_state = rnd64();
    req0_key = rnd64();
    exp0 = model_encrypt(req0_state, req0_key);
    req0_valid = 1'b1;
    wait_accept(0, acc);
    wait_out(res, id, seen);
    checks++;
    if (res !== exp0 || id !== 1'b0 || seen - acc != 28) begin
      errors++;
      $display("FAIL wd_later: got %b/%h lat %0d, required 0/%h lat 28",
               id, res, seen - acc, exp0);
    end
    @(negedge clk);
  endtask

  task automatic test_corner();
    logic [63:0] pts[5];
    logic [63:0] keys[5];
    logic [63:0] res, exp;
    logic id;
    int acc, prev, seen;
    pts[0] = 64'h0;
    keys[0] = 64'h0;
    pts[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    keys[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    pts[2] = 64'hAAAA_AAAA_AAAA_AAAA;
    keys[2] = 64'h5555_5555_5555_5555;
    pts[3] = 64'h5555_5555_5555_5555;
    keys[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    pts[4] = rnd64();
    keys[4] = rnd64();
    do_reset();
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      req1_state = pts[i];
      req1_key = keys[i];
      exp = model_encrypt(pts[i], keys[i]);
      req1_valid = 1'b1;
      wait_accept(1, acc);
      if (i > 0) begin
        checks++;
        if (acc - prev != 30) begin
          errors++;
          $display("FAIL corner_spacing%0d: got %0d, required 30",
                   i, acc - prev);
        end
      end
      prev = acc;
      wait_out(res, id, seen);
      checks++;
      if (res !== exp || id !== 1'b1) begin
        errors++;
        $display("FAIL corner%0d: got %b/%h, required 1/%h",
                 i, id, res, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] res, exp;
    logic id;
    int acc, seen, n;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(0, 1));
      out_ready = 1'b0;
      if (n == 0) begin
        req0_state = rnd64();
        req0_key = rnd64();
        exp = model_encrypt(req0_state, req0_key);
        req0_valid = 1'b1;
      end else begin
        req1_state = rnd64();
        req1_key = rnd64();
        exp = model_encrypt(req1_state, req1_key);
        req1_valid = 1'b1;
      end
      wait_accept(n, acc);
      wait_out(res, id, seen);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      checks++;
      if (out_result !== exp || out_id !== n[0]
          || seen - acc != 28) begin
        errors++;
        $display("FAIL rand%0d: got %b/%h lat %0d, required %0d/%h lat 28",
                 t, out_id, out_result, seen - acc, n, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    test_corner();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
